// File: rtl/act_pwm_pkg.sv
// Shared types and helpers for the multi-channel actuator PWM ramp controller.
// Holds the per-channel ramp FSM encoding, the channel-slice helper for packed
// outputs, and parameter-legality checks evaluated by the top at elaboration.
package act_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    // LSB position of channel ch inside a bus packed as NUM_CH fields of width bits.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

    // The PWM counter and duty share DUTY_W bits, and the counter must reach PERIOD-1.
    function automatic bit period_fits(input int period, input int duty_w);
        return (period >= 1) && (period <= (2 ** duty_w) - 1);
    endfunction

    // A press must move the target by a nonzero amount that does not exceed full scale.
    function automatic bit step_fits(input int step, input int period);
        return (step >= 1) && (step <= period);
    endfunction

endpackage

// File: rtl/act_btn_sync.sv
// Button conditioner: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Latency: pulse is high in the cycle after the 2nd sampling edge (plus DEB_CYCLES when debounced).
// Backpressure: none; one single-cycle pulse per accepted press however long it is held.
// Ports: clk, reset (sync, active-high), btn (raw async level), pulse (1-cycle press pulse).
// Option: ACT_DEBOUNCE_EN adds a DEB_CYCLES stable-level filter after the synchroniser.
module act_btn_sync #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_prev;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("act_btn_sync: DEB_CYCLES must be >= 1");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef ACT_DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [CNT_W-1:0] deb_cnt;
    logic             deb_level;

    // The new level is accepted on the DEB_CYCLES-th consecutive cycle that differs
    // from the accepted level; any return to the old level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (sync2 != deb_level) begin
            if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign level = deb_level;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    // Combinational so the target register can act on the very next edge.
    assign pulse = level & ~level_prev;

endmodule

// File: rtl/act_pwm_ramp_ctrl.sv
// Multi-channel actuator drive: button-set saturating target, slew-limited duty, glitch-free PWM.
// Latency: target moves 2 edges after a press is first sampled; duty moves 1 step per ramp tick.
// Backpressure: none; presses always accepted, enable=0 freezes ramp and PWM (forces pwm low).
// Ports: clk, reset (sync, active-high), inc/dec [NUM_CH] raw buttons, enable,
//        pwm [NUM_CH], duty/target [NUM_CH*DUTY_W] (channel i at [i*DUTY_W +: DUTY_W]),
//        at_target [NUM_CH]. Option: ACT_DEBOUNCE_EN enables button debounce (DEB_CYCLES).
module act_pwm_ramp_ctrl
    import act_pwm_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DUTY_W     = 8,
    parameter int PERIOD     = 100,
    parameter int STEP       = 5,
    parameter int RAMP_DIV   = 1000,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        inc,
    input  logic [NUM_CH-1:0]        dec,
    input  logic                     enable,
    output logic [NUM_CH-1:0]        pwm,
    output logic [NUM_CH*DUTY_W-1:0] duty,
    output logic [NUM_CH*DUTY_W-1:0] target,
    output logic [NUM_CH-1:0]        at_target
);

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    // Target arithmetic is one bit wider so the +STEP result can be clamped, never wrapped.
    localparam logic [DUTY_W:0] STEP_X   = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0] PERIOD_X = (DUTY_W + 1)'(PERIOD);

    if (!period_fits(PERIOD, DUTY_W)) begin : g_bad_period
        $error("act_pwm_ramp_ctrl: PERIOD must be in 1..2**DUTY_W-1");
    end
    if (!step_fits(STEP, PERIOD)) begin : g_bad_step
        $error("act_pwm_ramp_ctrl: STEP must be in 1..PERIOD");
    end
    if (RAMP_DIV < 1) begin : g_bad_ramp
        $error("act_pwm_ramp_ctrl: RAMP_DIV must be >= 1");
    end

    // Shared ramp prescaler; tick is gated by enable so a disabled block never ramps.
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = enable && (pre_cnt == PRE_W'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

    // Shared PWM period counter, parked at 0 while disabled so re-enable starts a full period.
    logic [DUTY_W-1:0] pwm_cnt;
    logic              period_end;

    assign period_end = enable && (pwm_cnt == DUTY_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              inc_pulse;
        logic              dec_pulse;
        logic [DUTY_W-1:0] tgt_q;
        logic [DUTY_W:0]   tgt_up;
        logic [DUTY_W:0]   tgt_dn;
        logic [DUTY_W-1:0] duty_q;
        logic [DUTY_W-1:0] duty_nxt;
        logic [DUTY_W-1:0] duty_plus;
        logic [DUTY_W-1:0] duty_minus;
        logic [DUTY_W-1:0] shadow_q;
        logic              pwm_q;
        logic              at_tgt;
        ramp_state_t       state_q;
        ramp_state_t       state_nxt;

        act_btn_sync #(.DEB_CYCLES(DEB_CYCLES)) u_inc_sync (
            .clk   (clk),
            .reset (reset),
            .btn   (inc[i]),
            .pulse (inc_pulse)
        );

        act_btn_sync #(.DEB_CYCLES(DEB_CYCLES)) u_dec_sync (
            .clk   (clk),
            .reset (reset),
            .btn   (dec[i]),
            .pulse (dec_pulse)
        );

        // Target: saturating +/-STEP. A simultaneous inc and dec cancel.
        // STEP <= PERIOD < 2**DUTY_W, so the borrow bit of tgt_dn flags underflow exactly.
        assign tgt_up = {1'b0, tgt_q} + STEP_X;
        assign tgt_dn = {1'b0, tgt_q} - STEP_X;

        always_ff @(posedge clk) begin
            if (reset) begin
                tgt_q <= '0;
            end else if (inc_pulse && !dec_pulse) begin
                tgt_q <= (tgt_up > PERIOD_X) ? PERIOD_X[DUTY_W-1:0] : tgt_up[DUTY_W-1:0];
            end else if (dec_pulse && !inc_pulse) begin
                tgt_q <= tgt_dn[DUTY_W] ? '0 : tgt_dn[DUTY_W-1:0];
            end
        end

        // Ramp FSM: state register (duty travels with the state).
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                duty_q  <= '0;
            end else begin
                state_q <= state_nxt;
                duty_q  <= duty_nxt;
            end
        end

        assign duty_plus  = duty_q + 1'b1;
        assign duty_minus = duty_q - 1'b1;

        // Ramp FSM: next state. The target seen here is the registered (pre-update) one,
        // so a tick coinciding with a target change steps against the old target.
        // A reversal only changes direction on that cycle; stepping resumes on the next tick.
        always_comb begin
            state_nxt = state_q;
            duty_nxt  = duty_q;
            case (state_q)
                IDLE: begin
                    if (tgt_q > duty_q) begin
                        state_nxt = UP;
                    end else if (tgt_q < duty_q) begin
                        state_nxt = DOWN;
                    end
                end
                UP: begin
                    if (tgt_q < duty_q) begin
                        state_nxt = DOWN;
                    end else if (tgt_q == duty_q) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        duty_nxt = duty_plus;
                        if (duty_plus == tgt_q) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                DOWN: begin
                    if (tgt_q > duty_q) begin
                        state_nxt = UP;
                    end else if (tgt_q == duty_q) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        duty_nxt = duty_minus;
                        if (duty_minus == tgt_q) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        // Ramp FSM: outputs.
        always_comb begin
            at_tgt = (state_q == IDLE);
        end

        // Shadow duty only changes at the period boundary so no pulse is ever cut short.
        always_ff @(posedge clk) begin
            if (reset) begin
                shadow_q <= '0;
                pwm_q    <= 1'b0;
            end else begin
                if (period_end) begin
                    shadow_q <= duty_q;
                end
                pwm_q <= enable && (pwm_cnt < shadow_q);
            end
        end

        assign pwm[i]                             = pwm_q;
        assign at_target[i]                       = at_tgt;
        assign duty[ch_lsb(i, DUTY_W) +: DUTY_W]   = duty_q;
        assign target[ch_lsb(i, DUTY_W) +: DUTY_W] = tgt_q;
    end

endmodule

// File: tb/tb_act_pwm_ramp_ctrl.sv
// Directed bench for act_pwm_ramp_ctrl with NUM_CH=2, DUTY_W=4, PERIOD=10, STEP=4, RAMP_DIV=4.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// With ACT_DEBOUNCE_EN defined only the reset and debounce scenarios are run (DEB_CYCLES=8).
module tb_act_pwm_ramp_ctrl;

    localparam int NUM_CH     = 2;
    localparam int DUTY_W     = 4;
    localparam int PERIOD     = 10;
    localparam int STEP       = 4;
    localparam int RAMP_DIV   = 4;
    localparam int DEB_CYCLES = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        inc;
    logic [NUM_CH-1:0]        dec;
    logic                     enable;
    logic [NUM_CH-1:0]        pwm;
    logic [NUM_CH*DUTY_W-1:0] duty;
    logic [NUM_CH*DUTY_W-1:0] target;
    logic [NUM_CH-1:0]        at_target;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    act_pwm_ramp_ctrl #(
        .NUM_CH     (NUM_CH),
        .DUTY_W     (DUTY_W),
        .PERIOD     (PERIOD),
        .STEP       (STEP),
        .RAMP_DIV   (RAMP_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc),
        .dec       (dec),
        .enable    (enable),
        .pwm       (pwm),
        .duty      (duty),
        .target    (target),
        .at_target (at_target)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges with everything idle; returns just after the last reset edge with reset low.
    task automatic do_reset();
        reset  = 1'b1;
        inc    = '0;
        dec    = '0;
        enable = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One-cycle press; the target moves on the 3rd edge, and the 4 idle cycles let the edge detector re-arm.
    task automatic press(input int ch, input bit up);
        if (up) inc[ch] = 1'b1;
        else    dec[ch] = 1'b1;
        step();
        inc = '0;
        dec = '0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        inc    = '0;
        dec    = '0;
        enable = 1'b1;
        step();
        step();
        checks++; if (target !== 8'h00) begin failures++; $display("FAIL reset_target: got %h expected 00", target); end
        checks++; if (duty !== 8'h00) begin failures++; $display("FAIL reset_duty: got %h expected 00", duty); end
        checks++; if (pwm !== 2'b00) begin failures++; $display("FAIL reset_pwm: got %b expected 00", pwm); end
        checks++; if (at_target !== 2'b11) begin failures++; $display("FAIL reset_at_target: got %b expected 11", at_target); end
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_inc_saturate();
        do_reset();
        enable = 1'b1;
        inc[0] = 1'b1;
        step();
        checks++; if (target[3:0] !== 4'd0) begin failures++; $display("FAIL inc_lat_k: got %0d expected 0", target[3:0]); end
        step();
        checks++; if (target[3:0] !== 4'd0) begin failures++; $display("FAIL inc_lat_k1: got %0d expected 0", target[3:0]); end
        step();
        checks++; if (target[3:0] !== 4'd4) begin failures++; $display("FAIL inc_lat_k2: got %0d expected 4", target[3:0]); end
        repeat (5) step();
        checks++; if (target[3:0] !== 4'd4) begin failures++; $display("FAIL inc_held_once: got %0d expected 4", target[3:0]); end
        inc[0] = 1'b0;
        repeat (4) step();
        press(0, 1'b1);
        checks++; if (target[3:0] !== 4'd8) begin failures++; $display("FAIL inc_second: got %0d expected 8", target[3:0]); end
        press(0, 1'b1);
        checks++; if (target[3:0] !== 4'd10) begin failures++; $display("FAIL inc_saturate: got %0d expected 10", target[3:0]); end
        press(0, 1'b1);
        checks++; if (target[3:0] !== 4'd10) begin failures++; $display("FAIL inc_stay_sat: got %0d expected 10", target[3:0]); end
        checks++; if (target[7:4] !== 4'd0) begin failures++; $display("FAIL inc_ch1_idle: got %0d expected 0", target[7:4]); end
    endtask

    task automatic test_ramp_up();
        int          sh_tab [5] = '{0, 2, 4, 7, 8};
        logic [3:0]  exp_duty;
        logic        exp_pwm;
        logic        exp_at;
        do_reset();
        press(0, 1'b1);
        press(0, 1'b1);
        checks++; if (target[3:0] !== 4'd8) begin failures++; $display("FAIL up_target_disabled: got %0d expected 8", target[3:0]); end
        checks++; if (duty[3:0] !== 4'd0) begin failures++; $display("FAIL up_duty_frozen: got %0d expected 0", duty[3:0]); end
        checks++; if (at_target !== 2'b10) begin failures++; $display("FAIL up_at_target_pre: got %b expected 10", at_target); end
        enable = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            step();
            exp_duty = 4'((n / 4 > 8) ? 8 : n / 4);
            exp_pwm  = ((n - 1) % 10) < sh_tab[(n - 1) / 10];
            exp_at   = (n >= 32);
            checks++; if (duty[3:0] !== exp_duty) begin failures++; $display("FAIL up_duty n=%0d: got %0d expected %0d", n, duty[3:0], exp_duty); end
            checks++; if (pwm[0] !== exp_pwm) begin failures++; $display("FAIL up_pwm n=%0d: got %b expected %b", n, pwm[0], exp_pwm); end
            checks++; if (at_target[0] !== exp_at) begin failures++; $display("FAIL up_at_target n=%0d: got %b expected %b", n, at_target[0], exp_at); end
        end
        checks++; if (pwm[1] !== 1'b0) begin failures++; $display("FAIL up_ch1_pwm: got %b expected 0", pwm[1]); end
    endtask

    task automatic test_reverse();
        int          sh_tab [6] = '{0, 2, 4, 4, 2, 0};
        logic [3:0]  exp_duty;
        logic [3:0]  exp_tgt;
        logic        exp_pwm;
        logic        exp_at;
        do_reset();
        press(0, 1'b1);
        press(0, 1'b1);
        enable = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n <= 20)      exp_duty = 4'(n / 4);
            else if (n < 28)  exp_duty = 4'd5;
            else if (n >= 44) exp_duty = 4'd0;
            else              exp_duty = 4'(5 - (n - 24) / 4);
            exp_tgt = (n < 23) ? 4'd8 : ((n < 25) ? 4'd4 : 4'd0);
            exp_pwm = ((n - 1) % 10) < sh_tab[(n - 1) / 10];
            exp_at  = (n >= 44);
            checks++; if (duty[3:0] !== exp_duty) begin failures++; $display("FAIL rev_duty n=%0d: got %0d expected %0d", n, duty[3:0], exp_duty); end
            checks++; if (target[3:0] !== exp_tgt) begin failures++; $display("FAIL rev_target n=%0d: got %0d expected %0d", n, target[3:0], exp_tgt); end
            checks++; if (pwm[0] !== exp_pwm) begin failures++; $display("FAIL rev_pwm n=%0d: got %b expected %b", n, pwm[0], exp_pwm); end
            checks++; if (at_target[0] !== exp_at) begin failures++; $display("FAIL rev_at_target n=%0d: got %b expected %b", n, at_target[0], exp_at); end
            dec[0] = (n == 20) || (n == 22);
        end
    endtask

    task automatic test_same_cycle_hold();
        do_reset();
        press(0, 1'b0);
        checks++; if (target[3:0] !== 4'd0) begin failures++; $display("FAIL dec_floor: got %0d expected 0", target[3:0]); end
        press(1, 1'b1);
        checks++; if (target[7:4] !== 4'd4) begin failures++; $display("FAIL ch1_inc: got %0d expected 4", target[7:4]); end
        inc[1] = 1'b1;
        dec[1] = 1'b1;
        step();
        inc = '0;
        dec = '0;
        repeat (4) step();
        checks++; if (target[7:4] !== 4'd4) begin failures++; $display("FAIL ch1_inc_dec_cancel: got %0d expected 4", target[7:4]); end
        inc[1] = 1'b1;
        repeat (100) step();
        checks++; if (target[7:4] !== 4'd8) begin failures++; $display("FAIL ch1_hold_single: got %0d expected 8", target[7:4]); end
        inc[1] = 1'b0;
        repeat (4) step();
        press(1, 1'b0);
        checks++; if (target[7:4] !== 4'd4) begin failures++; $display("FAIL ch1_dec: got %0d expected 4", target[7:4]); end
        checks++; if (target[3:0] !== 4'd0) begin failures++; $display("FAIL ch0_untouched: got %0d expected 0", target[3:0]); end
    endtask

    task automatic test_enable();
        logic [3:0] exp_duty;
        logic       exp_pwm;
        do_reset();
        press(0, 1'b1);
        press(0, 1'b1);
        enable = 1'b1;
        repeat (24) step();
        checks++; if (duty[3:0] !== 4'd6) begin failures++; $display("FAIL en_duty_before: got %0d expected 6", duty[3:0]); end
        checks++; if (pwm[0] !== 1'b1) begin failures++; $display("FAIL en_pwm_before: got %b expected 1", pwm[0]); end
        enable = 1'b0;
        step();
        checks++; if (pwm[0] !== 1'b0) begin failures++; $display("FAIL en_pwm_off: got %b expected 0", pwm[0]); end
        press(0, 1'b1);
        repeat (10) step();
        checks++; if (target[3:0] !== 4'd10) begin failures++; $display("FAIL en_target_while_off: got %0d expected 10", target[3:0]); end
        checks++; if (duty[3:0] !== 4'd6) begin failures++; $display("FAIL en_duty_frozen: got %0d expected 6", duty[3:0]); end
        checks++; if (pwm[0] !== 1'b0) begin failures++; $display("FAIL en_pwm_stays_off: got %b expected 0", pwm[0]); end
        checks++; if (at_target[0] !== 1'b0) begin failures++; $display("FAIL en_at_target_off: got %b expected 0", at_target[0]); end
        enable = 1'b1;
        for (int m = 1; m <= 20; m++) begin
            step();
            exp_pwm  = (m <= 10) ? (m <= 4) : (m <= 18);
            exp_duty = 4'((6 + m / 4 > 10) ? 10 : 6 + m / 4);
            checks++; if (pwm[0] !== exp_pwm) begin failures++; $display("FAIL en_restart_pwm m=%0d: got %b expected %b", m, pwm[0], exp_pwm); end
            checks++; if (duty[3:0] !== exp_duty) begin failures++; $display("FAIL en_restart_duty m=%0d: got %0d expected %0d", m, duty[3:0], exp_duty); end
        end
        checks++; if (at_target[0] !== 1'b1) begin failures++; $display("FAIL en_at_target_end: got %b expected 1", at_target[0]); end
        // Shadow is now 10, so the next period would be solidly high; reset must cut it.
        reset = 1'b1;
        step();
        checks++; if (pwm[0] !== 1'b0) begin failures++; $display("FAIL midrun_reset_pwm: got %b expected 0", pwm[0]); end
        checks++; if (duty !== 8'h00) begin failures++; $display("FAIL midrun_reset_duty: got %h expected 00", duty); end
        checks++; if (target !== 8'h00) begin failures++; $display("FAIL midrun_reset_target: got %h expected 00", target); end
        reset = 1'b0;
        repeat (3) step();
        checks++; if (pwm[0] !== 1'b0) begin failures++; $display("FAIL midrun_after_reset_pwm: got %b expected 0", pwm[0]); end
        checks++; if (at_target !== 2'b11) begin failures++; $display("FAIL midrun_after_reset_at: got %b expected 11", at_target); end
        enable = 1'b0;
    endtask

    task automatic test_debounce();
        do_reset();
        inc[0] = 1'b1;
        repeat (5) step();
        inc[0] = 1'b0;
        repeat (20) step();
        checks++; if (target[3:0] !== 4'd0) begin failures++; $display("FAIL deb_glitch: got %0d expected 0", target[3:0]); end
        inc[0] = 1'b1;
        repeat (10) step();
        checks++; if (target[3:0] !== 4'd0) begin failures++; $display("FAIL deb_k9: got %0d expected 0", target[3:0]); end
        step();
        checks++; if (target[3:0] !== 4'd4) begin failures++; $display("FAIL deb_k10: got %0d expected 4", target[3:0]); end
        inc[0] = 1'b0;
        repeat (20) step();
        checks++; if (target[3:0] !== 4'd4) begin failures++; $display("FAIL deb_release: got %0d expected 4", target[3:0]); end
    endtask

    initial begin
        reset  = 1'b1;
        inc    = '0;
        dec    = '0;
        enable = 1'b0;
        test_reset();
`ifdef ACT_DEBOUNCE_EN
        test_debounce();
`else
        test_inc_saturate();
        test_ramp_up();
        test_reverse();
        test_same_cycle_hold();
        test_enable();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
